// File: rtl/fetch_redirect_if.sv
// Fetch-stage control bundle: redirect requests and stalls in, fetch controls out.
// master = pipeline/hazard side, slave = fetch_redirect_controller.
interface fetch_redirect_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  trap_valid;
    logic [ADDR_WIDTH-1:0] trap_pc;
    logic                  mispredict_valid;
    logic [ADDR_WIDTH-1:0] mispredict_pc;
    logic                  early_valid;
    logic [ADDR_WIDTH-1:0] early_pc;
    logic                  hazard_stall;
    logic                  mem_stall;

    logic                  fetch_stall;
    logic                  fetch_flush;
    logic                  decode_flush;
    logic                  irreg_valid;
    logic [ADDR_WIDTH-1:0] irreg_pc;
    logic [1:0]            state;
    logic [15:0]           redirect_count;

    modport master (
        output trap_valid, trap_pc, mispredict_valid, mispredict_pc,
               early_valid, early_pc, hazard_stall, mem_stall,
        input  fetch_stall, fetch_flush, decode_flush, irreg_valid,
               irreg_pc, state, redirect_count
    );

    modport slave (
        input  trap_valid, trap_pc, mispredict_valid, mispredict_pc,
               early_valid, early_pc, hazard_stall, mem_stall,
        output fetch_stall, fetch_flush, decode_flush, irreg_valid,
               irreg_pc, state, redirect_count
    );
endinterface

// File: rtl/fetch_redirect_controller.sv
// Fetch sequencer: post-reset boot hold, prioritised redirect arbitration
// (trap > mispredict > early) and a fixed-length fetch flush after each redirect.
module fetch_redirect_controller #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
    parameter int unsigned           BOOT_CYCLES  = 4,
    parameter int unsigned           FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    fetch_redirect_if.slave   bus
);

    localparam int unsigned BOOT_W  = (BOOT_CYCLES > 2) ? $clog2(BOOT_CYCLES) : 1;
    localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned CNT_W   = 16;

    localparam logic [BOOT_W-1:0]  BOOT_INIT  = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic               HAS_FLUSH_TAIL = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_REDIRECT = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [BOOT_W-1:0]  boot_cnt_q, boot_cnt_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic                  take;
    logic                  win_decode_flush;
    logic [ADDR_WIDTH-1:0] win_pc;

    // Fixed-priority winner among the redirect sources
    always_comb begin
        win_decode_flush = bus.trap_valid | bus.mispredict_valid;
        if (bus.trap_valid) begin
            win_pc = bus.trap_pc;
        end else if (bus.mispredict_valid) begin
            win_pc = bus.mispredict_pc;
        end else begin
            win_pc = bus.early_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= BOOT_INIT;
            flush_cnt_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        boot_cnt_d       = boot_cnt_q;
        flush_cnt_d      = flush_cnt_q;
        count_d          = count_q;
        take             = 1'b0;
        bus.fetch_stall  = 1'b1;
        bus.fetch_flush  = 1'b1;
        bus.decode_flush = 1'b1;
        bus.irreg_valid  = 1'b0;
        bus.irreg_pc     = '0;

        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == '0) begin
                    bus.irreg_valid = 1'b1;
                    bus.irreg_pc    = RESET_PC;
                    bus.fetch_stall = 1'b0;
                    state_d         = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - BOOT_W'(1);
                end
            end
            ST_RUN: begin
                bus.fetch_stall  = bus.hazard_stall | bus.mem_stall;
                bus.fetch_flush  = 1'b0;
                bus.decode_flush = 1'b0;
                take = bus.trap_valid | bus.mispredict_valid | bus.early_valid;
            end
            ST_REDIRECT: begin
                bus.fetch_stall  = bus.mem_stall;
                bus.decode_flush = 1'b0;
                // Counter holds while memory stalls; the last flush cycle is count 1
                if (!bus.mem_stall) begin
                    flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                    if (flush_cnt_q <= FLUSH_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                // Early jumps here come from an instruction already being squashed
                take = bus.trap_valid | bus.mispredict_valid;
            end
            default: begin
                state_d    = ST_BOOT;
                boot_cnt_d = BOOT_INIT;
            end
        endcase

        if (take) begin
            bus.irreg_valid  = 1'b1;
            bus.irreg_pc     = win_pc;
            bus.fetch_flush  = 1'b1;
            bus.fetch_stall  = 1'b0;
            bus.decode_flush = win_decode_flush;
            flush_cnt_d      = FLUSH_INIT;
            state_d          = HAS_FLUSH_TAIL ? ST_REDIRECT : ST_RUN;
            count_d          = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
        end

        // While reset is held the controller looks exactly like early boot
        if (rst) begin
            bus.fetch_stall  = 1'b1;
            bus.fetch_flush  = 1'b1;
            bus.decode_flush = 1'b1;
            bus.irreg_valid  = 1'b0;
            bus.irreg_pc     = '0;
        end
        bus.state          = rst ? 2'(ST_BOOT) : 2'(state_q);
        bus.redirect_count = count_q;
    end

endmodule

// File: tb/tb_fetch_redirect_controller.sv
// Self-checking bench for fetch_redirect_controller: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_fetch_redirect_controller;

    localparam int unsigned AW           = 32;
    localparam logic [AW-1:0] RESET_PC   = '0;
    localparam int unsigned BOOT_CYCLES  = 4;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned VW           = 4 + AW + 2 + 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_redirect_if #(.ADDR_WIDTH(AW)) bus ();

    fetch_redirect_controller #(
        .ADDR_WIDTH  (AW),
        .RESET_PC    (RESET_PC),
        .BOOT_CYCLES (BOOT_CYCLES),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase 0 boot, 1 run, 2 flushing after a redirect
    int m_phase, m_boot_left, m_flush_left, m_count;
    int n_phase, n_boot_left, n_flush_left, n_count;
    logic [VW-1:0] exp_vec;

    function automatic logic [VW-1:0] obs_vec();
        return {bus.fetch_stall, bus.fetch_flush, bus.decode_flush, bus.irreg_valid,
                bus.irreg_pc, bus.state, bus.redirect_count};
    endfunction

    task automatic model_eval();
        logic st, ff, df, iv;
        logic [AW-1:0] pc;
        bit accept;
        int shown_phase;
        st = 1; ff = 1; df = 1; iv = 0; pc = '0; accept = 0;
        shown_phase  = m_phase;
        n_phase      = m_phase;
        n_boot_left  = m_boot_left;
        n_flush_left = m_flush_left;
        n_count      = m_count;
        if (rst) begin
            shown_phase  = 0;
            n_phase      = 0;
            n_boot_left  = BOOT_CYCLES - 1;
            n_flush_left = 0;
            n_count      = 0;
        end else if (m_phase == 0) begin
            if (m_boot_left == 0) begin
                iv = 1; pc = RESET_PC; st = 0; n_phase = 1;
            end else begin
                n_boot_left = m_boot_left - 1;
            end
        end else if (m_phase == 1) begin
            st = bus.hazard_stall | bus.mem_stall; ff = 0; df = 0;
            accept = bus.trap_valid | bus.mispredict_valid | bus.early_valid;
        end else begin
            st = bus.mem_stall; df = 0;
            if (!bus.mem_stall) begin
                n_flush_left = m_flush_left - 1;
                if (n_flush_left == 0) n_phase = 1;
            end
            accept = bus.trap_valid | bus.mispredict_valid;
        end
        if (accept) begin
            iv = 1; ff = 1; st = 0;
            df = bus.trap_valid | bus.mispredict_valid;
            pc = bus.trap_valid ? bus.trap_pc :
                 bus.mispredict_valid ? bus.mispredict_pc : bus.early_pc;
            n_count      = (m_count < 65535) ? m_count + 1 : 65535;
            n_flush_left = FLUSH_CYCLES - 1;
            n_phase      = (FLUSH_CYCLES > 1) ? 2 : 1;
        end
        exp_vec = {st, ff, df, iv, pc, 2'(shown_phase), 16'(m_count)};
    endtask

    task automatic set_in(input logic t, input logic [AW-1:0] tpc,
                          input logic m, input logic [AW-1:0] mpc,
                          input logic e, input logic [AW-1:0] epc,
                          input logic haz, input logic mem);
        bus.trap_valid       = t;
        bus.trap_pc          = tpc;
        bus.mispredict_valid = m;
        bus.mispredict_pc    = mpc;
        bus.early_valid      = e;
        bus.early_pc         = epc;
        bus.hazard_stall     = haz;
        bus.mem_stall        = mem;
        #1;
        model_eval();
    endtask

    task automatic idle();
        set_in(0, '0, 0, '0, 0, '0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        m_phase      = n_phase;
        m_boot_left  = n_boot_left;
        m_flush_left = n_flush_left;
        m_count      = n_count;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        checks++;
        if ({bus.fetch_stall, bus.fetch_flush, bus.decode_flush, bus.irreg_valid} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 1110",
                     {bus.fetch_stall, bus.fetch_flush, bus.decode_flush, bus.irreg_valid});
        end
        tick();
        rst = 0;
        idle();
        checks++;
        if (bus.state !== 2'b00 || bus.redirect_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: state=%b count=%0d want 00/0", bus.state, bus.redirect_count);
        end
    endtask

    task automatic test_boot();
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if (bus.fetch_stall !== 1'b1 || bus.irreg_valid !== 1'b0) begin
                errors++;
                $display("FAIL boot_hold[%0d]: stall=%b iv=%b want 1/0", i, bus.fetch_stall, bus.irreg_valid);
            end
            tick();
        end
        idle();
        checks++;
        if (bus.irreg_valid !== 1'b1 || bus.irreg_pc !== 32'h0 || bus.fetch_stall !== 1'b0) begin
            errors++;
            $display("FAIL boot_release: iv=%b pc=%h stall=%b want 1/0/0",
                     bus.irreg_valid, bus.irreg_pc, bus.fetch_stall);
        end
        tick();
        idle();
        checks++;
        if (bus.state !== 2'b01) begin
            errors++;
            $display("FAIL boot_to_run: state=%b want 01", bus.state);
        end
    endtask

    task automatic test_mispredict();
        set_in(0, '0, 1, 32'h100, 0, '0, 1, 0);
        checks++;
        if ({bus.irreg_valid, bus.fetch_stall, bus.fetch_flush, bus.decode_flush} !== 4'b1011 ||
            bus.irreg_pc !== 32'h100) begin
            errors++;
            $display("FAIL mispredict_accept: iv/st/ff/df=%b pc=%h want 1011/100",
                     {bus.irreg_valid, bus.fetch_stall, bus.fetch_flush, bus.decode_flush}, bus.irreg_pc);
        end
        tick();
        idle();
        checks++;
        if (bus.fetch_flush !== 1'b1 || bus.irreg_valid !== 1'b0 || bus.irreg_pc !== 32'h0) begin
            errors++;
            $display("FAIL mispredict_tail: ff=%b iv=%b pc=%h want 1/0/0",
                     bus.fetch_flush, bus.irreg_valid, bus.irreg_pc);
        end
        tick();
        idle();
        checks++;
        if (bus.state !== 2'b01 || bus.redirect_count !== 16'd1) begin
            errors++;
            $display("FAIL mispredict_done: state=%b count=%0d want 01/1", bus.state, bus.redirect_count);
        end
    endtask

    task automatic test_simultaneous();
        set_in(1, 32'h80, 1, 32'h200, 1, 32'h300, 0, 0);
        checks++;
        if (bus.irreg_pc !== 32'h80 || bus.decode_flush !== 1'b1) begin
            errors++;
            $display("FAIL simultaneous_pick: pc=%h df=%b want 80/1", bus.irreg_pc, bus.decode_flush);
        end
        tick();
        idle();
        checks++;
        if (bus.redirect_count !== 16'd2) begin
            errors++;
            $display("FAIL simultaneous_count: count=%0d want 2", bus.redirect_count);
        end
        tick();
    endtask

    task automatic test_early();
        set_in(0, '0, 0, '0, 1, 32'h40, 0, 0);
        checks++;
        if (bus.irreg_pc !== 32'h40 || bus.decode_flush !== 1'b0 || bus.irreg_valid !== 1'b1) begin
            errors++;
            $display("FAIL early_accept: pc=%h df=%b iv=%b want 40/0/1",
                     bus.irreg_pc, bus.decode_flush, bus.irreg_valid);
        end
        tick();
        set_in(0, '0, 0, '0, 1, 32'h60, 0, 0);
        checks++;
        if (bus.irreg_valid !== 1'b0 || bus.fetch_flush !== 1'b1) begin
            errors++;
            $display("FAIL early_ignored: iv=%b ff=%b want 0/1", bus.irreg_valid, bus.fetch_flush);
        end
        tick();
        set_in(0, '0, 0, '0, 1, 32'h40, 0, 0);
        tick();
        set_in(0, '0, 1, 32'h44, 1, 32'h60, 0, 0);
        checks++;
        if (bus.irreg_pc !== 32'h44 || bus.decode_flush !== 1'b1) begin
            errors++;
            $display("FAIL early_then_mispredict: pc=%h df=%b want 44/1", bus.irreg_pc, bus.decode_flush);
        end
        tick();
        idle();
        checks++;
        if (bus.state !== 2'b10 || bus.fetch_flush !== 1'b1) begin
            errors++;
            $display("FAIL flush_reload: state=%b ff=%b want 10/1", bus.state, bus.fetch_flush);
        end
        tick();
    endtask

    task automatic test_mem_stall();
        set_in(0, '0, 1, 32'h500, 0, '0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(0, '0, 0, '0, 0, '0, 0, 1);
            checks++;
            if (bus.fetch_flush !== 1'b1 || bus.fetch_stall !== 1'b1 || bus.state !== 2'b10) begin
                errors++;
                $display("FAIL mem_stall_hold[%0d]: ff=%b st=%b state=%b want 1/1/10",
                         i, bus.fetch_flush, bus.fetch_stall, bus.state);
            end
            tick();
        end
        idle();
        checks++;
        if (bus.fetch_flush !== 1'b1 || bus.fetch_stall !== 1'b0) begin
            errors++;
            $display("FAIL mem_stall_release: ff=%b st=%b want 1/0", bus.fetch_flush, bus.fetch_stall);
        end
        tick();
        idle();
        checks++;
        if (bus.state !== 2'b01) begin
            errors++;
            $display("FAIL mem_stall_run: state=%b want 01", bus.state);
        end
    endtask

    task automatic test_reset_mid();
        set_in(1, 32'hC0, 0, '0, 0, '0, 0, 0);
        tick();
        rst = 1;
        idle();
        tick();
        rst = 0;
        idle();
        checks++;
        if (bus.state !== 2'b00 || bus.redirect_count !== 16'd0 || bus.fetch_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: state=%b count=%0d st=%b want 00/0/1",
                     bus.state, bus.redirect_count, bus.fetch_stall);
        end
        for (int i = 0; i < BOOT_CYCLES; i++) begin
            idle();
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_in($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 6) == 0, $urandom,
                   $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0);
            checks++;
            if (!rst && obs_vec() !== exp_vec) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec);
            end
            tick();
        end
        rst = 0;
        for (int i = 0; i < BOOT_CYCLES + FLUSH_CYCLES + 2; i++) begin
            idle();
            tick();
        end
    endtask

    task automatic test_saturation();
        rst = 1;
        idle();
        tick();
        rst = 0;
        for (int i = 0; i < BOOT_CYCLES; i++) begin
            idle();
            tick();
        end
        for (int i = 0; i < 32'h10000; i++) begin
            set_in(1, $urandom, $urandom_range(0, 1), $urandom, 0, '0, 0, 0);
            if (i % 4096 == 0) begin
                checks++;
                if (obs_vec() !== exp_vec) begin
                    errors++;
                    $display("FAIL saturation_walk[%0d]: got %h want %h", i, obs_vec(), exp_vec);
                end
            end
            tick();
        end
        idle();
        checks++;
        if (bus.redirect_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation_reach: count=%h want ffff", bus.redirect_count);
        end
        set_in(1, 32'h1234, 0, '0, 0, '0, 0, 0);
        tick();
        idle();
        checks++;
        if (bus.redirect_count !== 16'hFFFF || obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL saturation_hold: count=%h want ffff", bus.redirect_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_phase = 0; m_boot_left = 0; m_flush_left = 0; m_count = 0;
        rst = 1;
        test_reset();
        test_boot();
        test_mispredict();
        test_simultaneous();
        test_early();
        test_mem_stall();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
